// File: rtl/riscv_bpred_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
// Optional RAS is enabled by defining RISCV_BPRED_RAS_EN.
package riscv_bpred_pkg;

  typedef enum logic [1:0] {
    BTYPE_COND = 2'd0,
    BTYPE_JMP  = 2'd1,
    BTYPE_CALL = 2'd2,
    BTYPE_RET  = 2'd3
  } btype_e;

  // Weakly not-taken
  localparam logic [1:0] BHT_INIT = 2'b01;

  typedef struct packed {
    btype_e      btype;
    logic [31:0] target;
  } btb_data_t;

  // RET has priority over CALL, CALL over JMP; anything else is a conditional branch
  function automatic btype_e resolve_btype(input logic is_call, input logic is_ret,
                                           input logic is_jmp);
    if (is_ret)       return BTYPE_RET;
    else if (is_call) return BTYPE_CALL;
    else if (is_jmp)  return BTYPE_JMP;
    else              return BTYPE_COND;
  endfunction

endpackage

// File: rtl/riscv_bpred_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module riscv_bpred_ras #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      stack [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] top_idx;

  // ptr is the next free slot; the top sits just below it
  assign top_idx = ptr - PTR_W'(1);
  assign top     = stack[top_idx];
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && pop) begin
      ptr   <= ptr;
      count <= count;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (push && pop) stack[top_idx] <= push_data;
      else if (push)   stack[ptr]     <= push_data;
    end
  end

endmodule

// File: rtl/riscv_bpred.sv
// Branch predictor: direct-mapped BTB, 2-bit BHT, optional RAS (RISCV_BPRED_RAS_EN).
// Same-cycle lookup on pc_f; tables train one clock after each resolution.
module riscv_bpred
  import riscv_bpred_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = 32,
  parameter int unsigned BHT_ENTRIES = 256,
  parameter int unsigned RAS_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_f,
  output logic [31:0] pred_pc,
  output logic        pred_taken,
  input  logic        br_req,
  input  logic        br_taken,
  input  logic        br_untaken,
  input  logic [31:0] br_source,
  input  logic [31:0] br_pc,
  input  logic        br_is_call,
  input  logic        br_is_ret,
  input  logic        br_is_jmp
);

  localparam int unsigned BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W     = 30 - BTB_IDX_W;
  localparam int unsigned BHT_IDX_W = $clog2(BHT_ENTRIES);

  logic             btb_valid [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag   [BTB_ENTRIES];
  btb_data_t        btb_data  [BTB_ENTRIES];
  logic [1:0]       bht       [BHT_ENTRIES];

  logic [BTB_IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0]     f_tag, u_tag;
  logic [BHT_IDX_W-1:0] f_bht, u_bht;
  logic                 hit;
  btb_data_t            hit_data;
  logic                 unused_bits;

  assign f_idx = pc_f[BTB_IDX_W+1:2];
  assign f_tag = pc_f[31:BTB_IDX_W+2];
  assign f_bht = pc_f[BHT_IDX_W+1:2];
  assign u_idx = br_source[BTB_IDX_W+1:2];
  assign u_tag = br_source[31:BTB_IDX_W+2];
  assign u_bht = br_source[BHT_IDX_W+1:2];

  assign hit      = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign hit_data = btb_data[f_idx];

  assign unused_bits = ^{pc_f[1:0], br_source[1:0]};

`ifdef RISCV_BPRED_RAS_EN
  logic [31:0] ras_top;
  logic        ras_empty;

  riscv_bpred_ras #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (br_req && br_taken && br_is_call),
    .pop       (br_req && br_taken && br_is_ret),
    .push_data (br_source + 32'd4),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`endif

  // Combinational next-PC prediction
  always_comb begin
    pred_pc    = pc_f + 32'd4;
    pred_taken = 1'b0;
    if (hit) begin
      case (hit_data.btype)
        BTYPE_COND: begin
          if (bht[f_bht][1]) begin
            pred_pc    = hit_data.target;
            pred_taken = 1'b1;
          end
        end
        BTYPE_JMP, BTYPE_CALL: begin
          pred_pc    = hit_data.target;
          pred_taken = 1'b1;
        end
        BTYPE_RET: begin
`ifdef RISCV_BPRED_RAS_EN
          pred_pc    = ras_empty ? hit_data.target : ras_top;
`else
          pred_pc    = hit_data.target;
`endif
          pred_taken = 1'b1;
        end
      endcase
    end
  end

  // Valid bits and counters carry reset state
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_INIT;
    end else if (br_req) begin
      if (br_taken && !br_untaken && (bht[u_bht] != 2'd3))
        bht[u_bht] <= bht[u_bht] + 2'd1;
      else if (br_untaken && !br_taken && (bht[u_bht] != 2'd0))
        bht[u_bht] <= bht[u_bht] - 2'd1;
      if (br_taken) btb_valid[u_idx] <= 1'b1;
    end
  end

  // Tag and payload are qualified by the valid bit, so they need no reset
  always_ff @(posedge clk) begin
    if (!rst_n && br_req && br_taken) begin
      btb_tag[u_idx]         <= u_tag;
      btb_data[u_idx].target <= br_pc;
      btb_data[u_idx].btype  <= resolve_btype(br_is_call, br_is_ret, br_is_jmp);
    end
  end

endmodule

// File: doc/riscv_bpred.md
# riscv_bpred

Fetch-side branch predictor that consumes the registered branch-resolution bus driven by the execute stage (br_req/br_taken/br_untaken/br_source/br_pc/br_is_call/br_is_ret/br_is_jmp).
- Holds a direct-mapped BTB, a table of 2-bit BHT counters and a return-address stack (RAS).
- Gives fetch a same-cycle next-PC prediction for the current fetch PC.
- Trains its tables one clock after each resolution arrives.

## Interface
- BTB_ENTRIES, 32: BTB entries; power of two, 2 to 256.
- BHT_ENTRIES, 256: 2-bit counters; power of two, 2 to 4096.
- RAS_DEPTH, 8: RAS entries; power of two, 2 to 32.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous and active-high (asserted = 1), despite the name.
- pc_f  input  32  fetch PC to predict for; bits [1:0] ignored.
- pred_pc  output  32  predicted next fetch PC.
- pred_taken  output  1  1 when pred_pc is not pc_f+4 due to a prediction.
- br_req  input  1  resolution valid this cycle.
- br_taken  input  1  resolved taken.
- br_untaken  input  1  resolved not taken.
- br_source  input  32  PC of the resolved instruction.
- br_pc  input  32  resolved next PC; this is the target when taken.
- br_is_call  input  1  taken call (JAL/JALR, rd = x1).
- br_is_ret  input  1  taken return (JALR x1, imm 0).
- br_is_jmp  input  1  taken other jump.

## Operation
- **BTB entry fields:** valid, tag, target[31:0], type[1:0] (COND, JMP, CALL, RET).
  - Index = pc[log2(BTB_ENTRIES)+1:2]; tag = pc[31:log2(BTB_ENTRIES)+2].
- **BHT:** counters indexed by pc[log2(BHT_ENTRIES)+1:2].
- **Lookup (combinational on pc_f):**
  - hit = valid & tag match.
  - On a miss: pred_pc = pc_f+4, pred_taken = 0.
  - On a hit, by type:
    - JMP or CALL: pred_pc = target, pred_taken = 1.
    - COND: taken iff counter[1] = 1.
    - RET with the RAS non-empty: pred_pc = RAS top, pred_taken = 1.
    - RET with the RAS empty: uses target, pred_taken = 1.
- **Update, on the clock edge where br_req = 1:**
  - **BHT entry at br_source:**
    - br_taken = 1: increment, saturating at 3.
    - br_untaken = 1: decrement, saturating at 0.
    - Both or neither: no change.
    - Non-branch resolutions therefore train the counter toward not-taken; this is intended.
  - **BTB, when br_taken = 1:** write the entry at br_source with valid = 1, tag, target = br_pc, and type.
    - Type priority: RET over CALL over JMP; COND when none of the three is set.
    - An existing entry at that index is replaced unconditionally.
  - **BTB, when br_untaken = 1:** no BTB write.
  - **RAS:**
    - br_taken & br_is_call pushes br_source+4.
    - br_taken & br_is_ret pops.
    - Both set: the top is replaced with br_source+4 and the count is unchanged.
- **RAS boundaries:**
  - Circular buffer with pointer and count.
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH; the pointer wraps mod RAS_DEPTH.
  - Pop when empty is a no-op; count stays 0.
- **Arithmetic:** all PC arithmetic is 32-bit modulo 2^32; 0xFFFFFFFC+4 = 0x00000000.
- **Non-speculative training:** the RAS and tables train only from resolutions; there is no speculative state and no recovery logic.

## Timing
- **Prediction latency:** 0 cycles; pred_pc and pred_taken are pure combinational functions of pc_f and the current state.
- **Update latency:** 1 cycle. A resolution in cycle N is visible to lookups from cycle N+1.
- **No bypass:** a lookup in cycle N of the same PC sees the pre-update state.
- **Reset values:**
  - All BTB valid bits = 0, all counters = 2'b01 (weakly not-taken), RAS pointer = 0, count = 0.
  - So pred_taken = 0 and pred_pc = pc_f+4 during and after reset.
- **Reset with br_req asserted:** reset wins and the update is dropped.

## Configuration
- **RISCV_BPRED_RAS_EN defined:** the RAS is instantiated and RET hits use the RAS top when the RAS is non-empty.
- **RISCV_BPRED_RAS_EN undefined:**
  - No RAS storage.
  - RET hits predict the BTB target exactly like JMP.
  - br_is_call and br_is_ret affect only the stored type.

## Structure
- **Shared constants:** BTB type encodings (BTYPE_COND = 0, BTYPE_JMP = 1, BTYPE_CALL = 2, BTYPE_RET = 3) and the counter reset value go in riscv_defs.v alongside the existing INST/ALU constants.
- **Sub-module riscv_bpred_ras:**
  - Parameter DEPTH.
  - Ports: clk, rst_n, push, pop, push_data, top, empty.
  - Instantiated only under RISCV_BPRED_RAS_EN.
- **In the top module:** the BTB and BHT are flop arrays.

## Test plan
- **Reset then miss:** reset; pc_f = 0x100 gives pred_pc = 0x104, pred_taken = 0.
- **Conditional training:**
  - Resolve br_source = 0x200, br_pc = 0x180, taken, twice.
  - Then pc_f = 0x200 gives pred_pc = 0x180, pred_taken = 1.
  - Two untaken resolutions give pred_pc = 0x204, pred_taken = 0.
- **Counter saturation:** 5 taken then 1 untaken at 0x300 keeps the prediction taken (counter 3→2).
- **Call/return:**
  - Resolve call at 0x400 to 0x800, then ret at 0x810 to 0x404.
  - Resolve call at 0x500 to 0x800.
  - Then pc_f = 0x810 gives pred_pc = 0x504.
- **RAS overflow:**
  - RAS_DEPTH+1 calls from 0x1000, 0x1010, and so on, then RAS_DEPTH+1 rets.
  - The first RAS_DEPTH pops return the newest addresses in LIFO order.
  - Count ends at 0 with no underflow.
- **No-bypass and aliasing:**
  - An update in cycle N is not visible to a lookup of 0x200 in cycle N.
  - Writing 0x200 then 0x200+4·BTB_ENTRIES evicts the first; pc_f = 0x200 then predicts 0x204.
